fetch_queue_unit: RTL and testbench

- Parametrised in-order fetch/decode front end for the Tomasulo core.
- Requests instruction blocks from the instruction cache and decodes one word per cycle.
- Buffers decoded ops in a QDEPTH-entry queue and dispatches them to the reservation stations with a valid/ready handshake.
- Resolves jumps at decode and bgt branches at the queue head using register-file read ports. On a taken bgt it flushes the queue and redirects fetch.

---
 rtl/fetch_queue_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - in-order fetch/decode front end with decoded-op queue and bgt resolution
module fetch_queue_unit #(
    parameter int              WORD_W      = 32,
    parameter int              BLOCK_WORDS = 32,
    parameter int              REG_W       = 6,
    parameter int              QDEPTH      = 4,
    parameter int              AW          = 32,
    parameter logic [AW-1:0]   RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          ic_req,
    output logic [AW-1:0]                 ic_addr,
    input  logic                          ic_hit,
    input  logic [BLOCK_WORDS*WORD_W-1:0] ic_block,
    output logic                          disp_valid,
    input  logic                          disp_ready,
    output logic [2:0]                    disp_unit,
    output logic [REG_W-1:0]              disp_reg1,
    output logic [REG_W-1:0]              disp_reg2,
    output logic [REG_W-1:0]              disp_reg3,
    output logic                          disp_hasimm,
    output logic [WORD_W-1:0]             disp_imm,
    output logic [REG_W-1:0]              rd_addr_a,
    output logic [REG_W-1:0]              rd_addr_b,
    input  logic                          rd_ready_a,
    input  logic                          rd_ready_b,
    input  logic [WORD_W-1:0]             rd_data_a,
    input  logic [WORD_W-1:0]             rd_data_b,
    output logic                          halted
);
    localparam int            QAW       = $clog2(QDEPTH);
    localparam int            IW        = $clog2(BLOCK_WORDS);
    localparam logic [AW-1:0] OFF_MASK  = AW'((BLOCK_WORDS * 4) - 1);
    localparam logic [AW-1:0] BLK_BYTES = AW'(BLOCK_WORDS * 4);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {S_REQ, S_DECODE, S_HALTED} state_t;

    typedef struct packed {
        logic              br;
        logic [2:0]        unit;
        logic [REG_W-1:0]  r1;
        logic [REG_W-1:0]  r2;
        logic [REG_W-1:0]  r3;
        logic              hasimm;
        logic [WORD_W-1:0] imm;
        logic [AW-1:0]     target;
    } entry_t;

    state_t                  state;
    logic [AW-1:0]           pc;
    logic [AW-1:0]           blk_base;
    logic [IW-1:0]           idx;
    logic [BLOCK_WORDS*WORD_W-1:0] blk;
    entry_t                  q [QDEPTH];
    logic [QAW-1:0]          wr_ptr;
    logic [QAW-1:0]          rd_ptr;
    logic [QAW:0]            cnt;

    logic [WORD_W-1:0]       words [BLOCK_WORDS];
    logic [WORD_W-1:0]       inst;
    logic [AW-1:0]           dec_target;
    entry_t                  dec_e;
    logic                    dec_push;
    logic                    dec_jmp;
    logic                    dec_halt;

    entry_t                  head;
    logic                    empty;
    logic                    full;
    logic                    br_eval;
    logic                    br_taken;
    logic                    pop;
    logic                    consume;
    logic                    push;
    logic                    halt_pop;

    always_comb begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            words[k] = blk[(BLOCK_WORDS-1-k)*WORD_W +: WORD_W];
        end
    end

    assign inst       = words[idx];
    assign dec_target = blk_base + {{(AW-28){inst[27]}}, inst[27:0]};

    always_comb begin
        dec_e    = '0;
        dec_push = 1'b0;
        dec_jmp  = 1'b0;
        dec_halt = 1'b0;
        case (inst[31:28])
            4'b1000, 4'b1001, 4'b1100, 4'b1101: begin
                dec_push = 1'b1;
                case (inst[31:28])
                    4'b1100: dec_e.unit = 3'b000;
                    4'b1101: dec_e.unit = 3'b001;
                    4'b1000: dec_e.unit = 3'b010;
                    default: dec_e.unit = 3'b011;
                endcase
                dec_e.r1 = inst[27:22];
                dec_e.r2 = inst[21:16];
                if (inst[0]) begin
                    dec_e.hasimm = 1'b1;
                    dec_e.imm    = {{(WORD_W-15){inst[15]}}, inst[15:1]};
                end else begin
                    dec_e.r3 = inst[15:10];
                end
            end
            4'b1111: begin
                dec_push   = 1'b1;
                dec_e.unit = 3'b100;
                dec_e.r1   = inst[27:22];
                if (inst[0]) begin
                    dec_e.hasimm = 1'b1;
                    dec_e.imm    = {{(WORD_W-21){inst[21]}}, inst[21:1]};
                end else begin
                    dec_e.r2 = inst[21:16];
                end
            end
            4'b1110: dec_jmp = 1'b1;
            4'b1010: begin
                dec_push     = 1'b1;
                dec_e.br     = 1'b1;
                dec_e.r1     = inst[27:22];
                dec_e.r2     = inst[21:16];
                dec_e.target = dec_target;
            end
            4'b0001: begin
                dec_push   = 1'b1;
                dec_halt   = 1'b1;
                dec_e.unit = 3'b101;
            end
            default: ;
        endcase
    end

    assign head        = q[rd_ptr];
    assign empty       = (cnt == '0);
    assign full        = (cnt == (QAW+1)'(QDEPTH));
    assign disp_valid  = !empty && !head.br;
    assign disp_unit   = head.unit;
    assign disp_reg1   = head.r1;
    assign disp_reg2   = head.r2;
    assign disp_reg3   = head.r3;
    assign disp_hasimm = head.hasimm;
    assign disp_imm    = head.imm;
    assign rd_addr_a   = head.r1;
    assign rd_addr_b   = head.r2;

    // A branch at the head resolves only once both operands are committed.
    assign br_eval  = !empty && head.br && rd_ready_a && rd_ready_b;
    assign br_taken = br_eval && ($signed(rd_data_a) > $signed(rd_data_b));
    assign pop      = (disp_valid && disp_ready) || (br_eval && !br_taken);
    assign consume  = (state == S_DECODE) && !(full && !pop);
    assign push     = consume && dec_push && !br_taken;
    assign halt_pop = disp_valid && disp_ready && (head.unit == 3'b101);

    always_ff @(posedge clk) begin
        if (push) begin
            q[wr_ptr] <= dec_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            ic_req   <= 1'b0;
            ic_addr  <= RESET_PC;
            pc       <= RESET_PC;
            halted   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            idx      <= '0;
            blk      <= '0;
            blk_base <= '0;
        end else begin
            if (halt_pop) begin
                halted <= 1'b1;
            end
            if (br_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
            // A taken branch overrides whatever the fetch side was doing this cycle.
            if (br_taken) begin
                state  <= S_REQ;
                ic_req <= 1'b0;
                pc     <= head.target;
            end else begin
                case (state)
                    S_REQ: begin
                        if (!ic_req) begin
                            ic_req  <= 1'b1;
                            ic_addr <= pc & ~OFF_MASK;
                        end else if (ic_hit) begin
                            ic_req   <= 1'b0;
                            blk      <= ic_block;
                            blk_base <= pc & ~OFF_MASK;
                            idx      <= IW'((pc & OFF_MASK) >> 2);
                            state    <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (consume) begin
                            if (dec_jmp) begin
                                pc    <= dec_target;
                                state <= S_REQ;
                            end else if (dec_halt) begin
                                state <= S_HALTED;
                            end else if (idx == LAST_IDX) begin
                                pc    <= blk_base + BLK_BYTES;
                                state <= S_REQ;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    localparam int BW     = 32;
    localparam int NWORDS = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, ic_req, ic_hit, disp_valid, disp_ready, disp_hasimm;
    logic            rd_ready_a, rd_ready_b, halted;
    logic [31:0]     ic_addr, disp_imm, rd_data_a, rd_data_b;
    logic [BW*32-1:0] ic_block;
    logic [2:0]      disp_unit;
    logic [5:0]      disp_reg1, disp_reg2, disp_reg3, rd_addr_a, rd_addr_b;

    fetch_queue_unit dut (
        .clk(clk), .rst_n(rst_n), .ic_req(ic_req), .ic_addr(ic_addr), .ic_hit(ic_hit),
        .ic_block(ic_block), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_unit(disp_unit), .disp_reg1(disp_reg1), .disp_reg2(disp_reg2),
        .disp_reg3(disp_reg3), .disp_hasimm(disp_hasimm), .disp_imm(disp_imm),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ready_a(rd_ready_a),
        .rd_ready_b(rd_ready_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .halted(halted)
    );

    // Instruction memory aliases every 512 bytes; register file is a plain table.
    logic [31:0]        mem  [NWORDS];
    logic signed [31:0] regs [64];
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    logic [63:0] exp_q [$];
    logic [31:0] req_log [$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hit_cyc, valid_cyc, hit_delay, hold_cyc, rd_hold;
    bit mon_en, resp_en, rand_rdy, prev_req;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [2:0] u, input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] c, input logic hi, input logic [31:0] im);
        logic [63:0] p;
        p = '0;
        p[56:54] = u;
        if (u <= 3'b011) begin
            p[53:48] = a; p[47:42] = b; p[32] = hi;
            if (hi) p[31:0] = im; else p[41:36] = c;
        end else if (u == 3'b100) begin
            p[53:48] = a; p[32] = hi;
            if (hi) p[31:0] = im; else p[47:42] = b;
        end
        return p;
    endfunction

    function automatic logic [BW*32-1:0] block_at(input logic [31:0] a);
        logic [BW*32-1:0] b;
        int w0;
        w0 = int'((a >> 2) & 32'h60);
        for (int k = 0; k < BW; k++) b[(BW-1-k)*32 +: 32] = mem[w0 + k];
        return b;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Architectural walk of the program: the in-order list of ops that must be dispatched.
    task automatic build_model();
        logic [31:0] pc, w, base, off;
        logic [2:0] u;
        pc = 32'd0;
        exp_q.delete();
        for (int s = 0; s < 1000; s++) begin
            w    = mem[(pc >> 2) & 32'd127];
            base = pc & ~32'd127;
            off  = 32'($signed(w[27:0]));
            case (w[31:28])
                4'b1000, 4'b1001, 4'b1100, 4'b1101: begin
                    u = (w[31:28] == 4'b1100) ? 3'd0 : (w[31:28] == 4'b1101) ? 3'd1 :
                        (w[31:28] == 4'b1000) ? 3'd2 : 3'd3;
                    exp_q.push_back(pack(u, w[27:22], w[21:16], w[15:10], w[0], 32'($signed(w[15:1]))));
                    pc = pc + 4;
                end
                4'b1111: begin
                    exp_q.push_back(pack(3'd4, w[27:22], w[21:16], 6'd0, w[0], 32'($signed(w[21:1]))));
                    pc = pc + 4;
                end
                4'b1110: pc = base + off;
                4'b1010: pc = (regs[w[27:22]] > regs[w[21:16]]) ? base + off : pc + 4;
                4'b0001: begin
                    exp_q.push_back(pack(3'd5, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0));
                    return;
                end
                default: pc = pc + 4;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en && rst_n) begin
            if (ic_req && !prev_req) req_log.push_back(ic_addr);
            prev_req = ic_req;
            if (ic_req && ic_hit && hit_cyc < 0) hit_cyc = cyc;
            if (disp_valid && valid_cyc < 0) valid_cyc = cyc;
            if (disp_valid && disp_ready) begin
                if (exp_q.size() == 0) check("extra_dispatch", 64'(exp_q.size()), 64'd1);
                else check("dispatch", pack(disp_unit, disp_reg1, disp_reg2, disp_reg3, disp_hasimm, disp_imm),
                           exp_q.pop_front());
            end
            if (halted) check("no_req_after_halt", {63'd0, ic_req}, 64'd0);
        end
        @(posedge clk);
        cyc++;
        #1;
        ic_hit = 1'b0;
        if (resp_en && ic_req) begin
            if (hit_delay == 0) begin
                ic_hit    = 1'b1;
                ic_block  = block_at(ic_addr);
                hit_delay = $urandom_range(0, 3);
            end else hit_delay--;
        end
        if (hold_cyc > 0) begin disp_ready = 1'b0; hold_cyc--; end
        else disp_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (rd_hold > 0) begin rd_ready_a = 1'b0; rd_hold--; end
        else rd_ready_a = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        rd_ready_b = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic do_reset();
        mon_en = 0; resp_en = 0; rand_rdy = 0; hold_cyc = 0; rd_hold = 0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_ic_req", {63'd0, ic_req}, 64'd0);
        check("rst_disp_valid", {63'd0, disp_valid}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_ic_addr", 64'(ic_addr), 64'd0);
        rst_n = 1'b1;
        hit_cyc = -1; valid_cyc = -1; prev_req = 0;
        req_log.delete();
        hit_delay = $urandom_range(0, 2);
    endtask

    task automatic run_prog(input string name, input bit rnd, input int hold, input int rhold);
        build_model();
        do_reset();
        mon_en = 1; resp_en = 1; rand_rdy = rnd; hold_cyc = hold; rd_hold = rhold;
        for (int i = 0; i < 6000 && !halted; i++) tick();
        check({name, "_halted"}, {63'd0, halted}, 64'd1);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (8) tick();
    endtask

    function automatic logic [31:0] rnd_op(input logic [3:0] op);
        logic [31:0] w;
        w = $urandom;
        w[31:28] = op;
        return w;
    endfunction

    task automatic gen_prog();
        logic [3:0] nops [8];
        logic [3:0] alus [4];
        int r, t, base;
        nops = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB};
        alus = '{4'h8, 4'h9, 4'hC, 4'hD};
        for (int i = 0; i < NWORDS - 1; i++) begin
            r = $urandom_range(0, 99);
            base = (i / 32) * 128;
            if (r < 40) mem[i] = rnd_op(alus[$urandom_range(0, 3)]);
            else if (r < 55) mem[i] = rnd_op(4'hF);
            else if (r < 65) mem[i] = rnd_op(nops[$urandom_range(0, 7)]);
            else begin
                t = $urandom_range(i + 1, NWORDS - 1);
                mem[i] = rnd_op((r < 72) ? 4'hE : 4'hA);
                mem[i][8:0] = 9'(t * 4 - base);
            end
        end
        mem[NWORDS-1] = rnd_op(4'h1);
        foreach (regs[i]) regs[i] = $urandom_range(0, 40) - 20;
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 32'd0;
        foreach (regs[i]) regs[i] = i;
    endtask

    initial begin
        rst_n = 1'b0; ic_hit = 1'b0; ic_block = '0; disp_ready = 1'b0;
        rd_ready_a = 1'b0; rd_ready_b = 1'b0;

        clear_mem();
        mem[0] = {4'b1000, 6'd1, 6'd2, 15'd5, 1'b1};
        mem[1] = 32'h1000_0000;
        run_prog("basic", 0, 0, 0);
        check("basic_first_addr", 64'(req_at(0)), 64'd0);
        check("basic_hit_to_valid", 64'(valid_cyc - hit_cyc), 64'd2);
        check("basic_one_request", 64'(req_log.size()), 64'd1);

        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = rnd_op(4'h8);
        mem[6] = 32'h1000_0000;
        run_prog("fill", 0, 30, 0);

        clear_mem();
        mem[0]  = rnd_op(4'h8);
        mem[32] = 32'h1000_0000;
        run_prog("nops", 0, 0, 0);
        check("nops_next_block", 64'(req_at(1)), 64'd128);

        clear_mem();
        mem[0] = {4'b1110, 28'd256};
        for (int i = 1; i < 32; i++) mem[i] = rnd_op(4'h8);
        mem[64] = {4'b1110, 28'hFFF_FF80};
        mem[32] = rnd_op(4'h9);
        mem[33] = 32'h1000_0000;
        run_prog("jmp", 0, 0, 0);
        check("jmp_fwd_addr", 64'(req_at(1)), 64'd256);
        check("jmp_back_addr", 64'(req_at(2)), 64'd128);

        clear_mem();
        mem[0] = rnd_op(4'h8);
        mem[1] = {4'b1010, 6'd1, 6'd2, 16'h0100};
        for (int i = 2; i < 6; i++) mem[i] = rnd_op(4'hC);
        mem[6]  = 32'h1000_0000;
        mem[64] = rnd_op(4'hF);
        mem[65] = 32'h1000_0000;
        regs[1] = 7; regs[2] = 3;
        run_prog("bgt_taken", 0, 0, 10);
        check("bgt_taken_addr", 64'(req_at(1)), 64'h0042_0100);

        regs[1] = -1; regs[2] = 2;
        run_prog("bgt_not", 0, 0, 4);
        check("bgt_not_requests", 64'(req_log.size()), 64'd1);

        for (int r = 0; r < 10; r++) begin
            gen_prog();
            run_prog("rand", 1, (r == 0) ? 40 : 0, 0);
        end

        gen_prog();
        build_model();
        do_reset();
        mon_en = 1; resp_en = 1; rand_rdy = 1; hold_cyc = 1000;
        repeat (40) tick();
        do_reset();
        gen_prog();
        run_prog("after_reset", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
